// File: rtl/slot_fifo_pkg.sv
// slot_fifo_pkg: shared defaults and pointer helper for slot_fifo.
package slot_fifo_pkg;

  localparam int SLOT_FIFO_DEPTH_DEFAULT      = 4;
  localparam int SLOT_FIFO_LOG_DEPTH_DEFAULT  = 2;
  localparam int SLOT_FIFO_DATA_WIDTH_DEFAULT = 64;

  // Increment a slot pointer and wrap it modulo a power-of-two depth.
  function automatic logic [31:0] slot_fifo_next_ptr(
    input logic [31:0] ptr,
    input int unsigned num_slots = SLOT_FIFO_DEPTH_DEFAULT
  );
    return (ptr + 32'd1) & (num_slots - 32'd1);
  endfunction

endpackage

// File: rtl/slot_fifo_mem.sv
// slot_fifo_mem: register array, one synchronous write port, one async read
// port, asynchronous active-low clear of every entry.
module slot_fifo_mem
  import slot_fifo_pkg::*;
#(
  parameter int NUM_SLOTS     = SLOT_FIFO_DEPTH_DEFAULT,
  parameter int LOG_NUM_SLOTS = SLOT_FIFO_LOG_DEPTH_DEFAULT,
  parameter int DATA_WIDTH    = SLOT_FIFO_DATA_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [LOG_NUM_SLOTS-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [LOG_NUM_SLOTS-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

  // Next-state of the array: only the addressed slot changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage flops, cleared to zero on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else      mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/slot_fifo.sv
// slot_fifo: first-word-fall-through FIFO used as a pipeline-stage input
// buffer. almost_full leaves one slot of slack for upstream.
// Define FIFO_DEBUG_EN to get a cycle counter and a $display trace of
// accepted/dropped operations; behaviour is otherwise identical.
module slot_fifo
  import slot_fifo_pkg::*;
#(
  parameter int NUM_SLOTS     = SLOT_FIFO_DEPTH_DEFAULT,
  parameter int LOG_NUM_SLOTS = SLOT_FIFO_LOG_DEPTH_DEFAULT,
  parameter int DATA_WIDTH    = SLOT_FIFO_DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  localparam logic [LOG_NUM_SLOTS:0] CNT_ONE  = (LOG_NUM_SLOTS+1)'(1);
  localparam logic [LOG_NUM_SLOTS:0] CNT_FULL = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0] CNT_AF   = (LOG_NUM_SLOTS+1)'(NUM_SLOTS-1);

  logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_NUM_SLOTS:0]   count_q, count_d;
  logic                     push, pop;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_FULL);
  assign almost_full = (count_q >= CNT_AF);

  // Writes while full are dropped, reads while empty are ignored.
  assign push = write & ~full;
  assign pop  = next_read & ~empty;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = LOG_NUM_SLOTS'(slot_fifo_next_ptr(32'(wr_ptr_q), NUM_SLOTS));
    if (pop)  rd_ptr_d = LOG_NUM_SLOTS'(slot_fifo_next_ptr(32'(rd_ptr_q), NUM_SLOTS));
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  slot_fifo_mem #(
    .NUM_SLOTS     (NUM_SLOTS),
    .LOG_NUM_SLOTS (LOG_NUM_SLOTS),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (data_write),
    .raddr (rd_ptr_q),
    .rdata (data_read)
  );

`ifdef FIFO_DEBUG_EN
  logic [15:0] cyc_q, cyc_d;

  // Free-running cycle counter for trace timestamps.
  always_comb cyc_d = cyc_q + 16'd1;

  // Counter flop, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end

  // Trace of every accepted, dropped or ignored operation.
  always @(posedge clk) begin
    if (rst) begin
      if (push) $display("slot_fifo cyc %0d: push data=%0h count=%0d", cyc_q, data_write, count_d);
      if (pop)  $display("slot_fifo cyc %0d: pop  data=%0h count=%0d", cyc_q, data_read, count_d);
      if (write && full)      $display("slot_fifo cyc %0d: warning write dropped (full)", cyc_q);
      if (next_read && empty) $display("slot_fifo cyc %0d: warning read ignored (empty)", cyc_q);
    end
  end
`else
  // Debug trace disabled: no counter, no output.
`endif

endmodule

// File: tb/tb_slot_fifo.sv
// tb_slot_fifo: directed stimulus with a scoreboard queue; a negedge monitor
// checks data_read against the queue head for every accepted pop.
module tb_slot_fifo;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_write = '0;
  logic          write = 1'b0;
  logic          next_read = 1'b0;
  logic          full, almost_full, empty;
  logic [DW-1:0] data_read;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  slot_fifo #(.NUM_SLOTS(4), .LOG_NUM_SLOTS(2), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_write  (data_write),
    .write       (write),
    .full        (full),
    .almost_full (almost_full),
    .data_read   (data_read),
    .next_read   (next_read),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flags(input string name, input logic e, input logic af, input logic f);
    chk({name, ".empty"}, 64'(empty), 64'(e));
    chk({name, ".almost_full"}, 64'(almost_full), 64'(af));
    chk({name, ".full"}, 64'(full), 64'(f));
  endtask

  // One clock: apply inputs, take the edge, settle 1 time unit past it.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    write = w; data_write = d; next_read = r;
    @(posedge clk); #1;
    write = 1'b0; next_read = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    exp_q.push_back(d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, '0, 1'b1);
  endtask

  // Scoreboard monitor: every pop the DUT will accept must show the queue head.
  always @(negedge clk) begin
    if (rst && next_read && !empty) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected no entry", data_read);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (data_read !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h at %0t", data_read, e, $time);
        end
      end
    end
  end

  initial begin
    // Reset state
    #1;
    flags("reset0", 1'b1, 1'b0, 1'b0);
    chk("reset0.data_read", data_read, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Fill and drain with flag thresholds
    push(64'hA1); flags("fill1", 1'b0, 1'b0, 1'b0); chk("fwft_latency", data_read, 64'hA1);
    push(64'hA2); flags("fill2", 1'b0, 1'b0, 1'b0);
    push(64'hA3); flags("fill3", 1'b0, 1'b1, 1'b0);
    push(64'hA4); flags("fill4", 1'b0, 1'b1, 1'b1);
    // Overflow: dropped, not in the scoreboard
    cyc(1'b1, 64'hFF, 1'b0); flags("overflow", 1'b0, 1'b1, 1'b1);
    chk("overflow.head", data_read, 64'hA1);
    pop(); flags("drain1", 1'b0, 1'b1, 1'b0);
    pop(); flags("drain2", 1'b0, 1'b0, 1'b0);
    pop();
    pop(); flags("drain4", 1'b1, 1'b0, 1'b0);

    // Underflow ignored, then a push shows one cycle later
    pop(); flags("underflow", 1'b1, 1'b0, 1'b0);
    push(64'h5); flags("after_uf", 1'b0, 1'b0, 1'b0); chk("after_uf.data", data_read, 64'h5);
    pop(); flags("after_uf_pop", 1'b1, 1'b0, 1'b0);

    // Push+pop while empty: only the push lands
    exp_q.push_back(64'h66);
    cyc(1'b1, 64'h66, 1'b1); flags("pp_empty", 1'b0, 1'b0, 1'b0);
    chk("pp_empty.data", data_read, 64'h66);
    pop(); flags("pp_empty_pop", 1'b1, 1'b0, 1'b0);

    // Steady push+pop at count 2 for 10 cycles
    push(64'hB0); push(64'hB1);
    for (int i = 2; i < 12; i++) begin
      exp_q.push_back(64'hB0 + 64'(i));
      cyc(1'b1, 64'hB0 + 64'(i), 1'b1);
      flags("steady2", 1'b0, 1'b0, 1'b0);
    end
    pop(); pop(); flags("steady_done", 1'b1, 1'b0, 1'b0);

    // Push+pop at full: pop accepted, 0x77 dropped, count 3
    push(64'hC1); push(64'hC2); push(64'hC3); push(64'hC4);
    cyc(1'b1, 64'h77, 1'b1); flags("pp_full", 1'b0, 1'b1, 1'b0);
    chk("pp_full.head", data_read, 64'hC2);
    pop(); pop(); pop(); flags("pp_full_drain", 1'b1, 1'b0, 1'b0);

    // Wrap-around: offset of 1, nine entries streamed
    push(64'hD0);
    for (int i = 1; i < 9; i++) begin
      exp_q.push_back(64'hD0 + 64'(i));
      cyc(1'b1, 64'hD0 + 64'(i), 1'b1);
      flags("wrap", 1'b0, 1'b0, 1'b0);
      chk("wrap.head", data_read, 64'hD0 + 64'(i));
    end
    pop(); flags("wrap_done", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with 2 entries held
    push(64'hE1); push(64'hE2);
    #2 rst = 1'b0;
    #1;
    flags("async_rst", 1'b1, 1'b0, 1'b0);
    chk("async_rst.data_read", data_read, '0);
    exp_q.delete();
    cyc(1'b1, 64'h99, 1'b1); flags("rst_held", 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    push(64'hF1); flags("post_rst", 1'b0, 1'b0, 1'b0); chk("post_rst.data", data_read, 64'hF1);
    pop(); flags("post_rst_pop", 1'b1, 1'b0, 1'b0);

    chk("scoreboard_left", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
